// File: rtl/ad7980_pkg.sv
// Shared constants, FSM state encoding and sample helper for the AD7980 acquisition block.
package ad7980_pkg;

    localparam int ADC_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        CONV
    } acq_state_t;

    // Subtract b from a, clamping at zero instead of wrapping.
    function automatic logic [ADC_WIDTH-1:0] sat_sub(input logic [ADC_WIDTH-1:0] a,
                                                     input logic [ADC_WIDTH-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/ad7980_acq_fifo.sv
// Synchronous FIFO holding averaged words; head is shown combinationally on dout (zero when empty).
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ad7980_acq.sv
// AD7980 acquisition front end: periodic conversion trigger, sample averaging and output FIFO.
// Build macro AD7980_ACQ_OFFSET_EN adds an offset input subtracted (clamped at 0) from each sample.
module ad7980_acq
    import ad7980_pkg::*;
#(
    parameter int PERIOD     = 200,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic                 adc_start,
    input  logic                 adc_busy,
    input  logic [ADC_WIDTH-1:0] adc_data,
`ifdef AD7980_ACQ_OFFSET_EN
    input  logic [ADC_WIDTH-1:0] offset,
`endif
    output logic [ADC_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    input  logic                 clr_overrun
);
    localparam int CW    = $clog2(PERIOD);
    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int N_AVG = 1 << AVG_LOG2;

    acq_state_t           state;
    acq_state_t           state_next;
    logic [CW-1:0]        period_cnt;
    logic                 trigger;
    logic                 busy_q;
    logic                 busy_fall;
    logic                 capture;
    logic                 discard_q;
    logic                 sample_valid;
    logic [ADC_WIDTH-1:0] sample_in;
    logic [ADC_WIDTH-1:0] sample_q;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_sum;
    logic [CNT_W-1:0]     sample_cnt;
    logic                 last_sample;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 overrun_set;
    logic [ADC_WIDTH-1:0] word;

`ifdef AD7980_ACQ_OFFSET_EN
    assign sample_in = sat_sub(adc_data, offset);
`else
    assign sample_in = adc_data;
`endif

    assign trigger   = enable && (period_cnt == CW'(PERIOD - 1));
    assign busy_fall = busy_q & ~adc_busy;
    assign capture   = (state == CONV) & busy_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (!enable || period_cnt == CW'(PERIOD - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        adc_start  = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    adc_start  = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (adc_busy)  state_next = CONV;
            CONV:      if (busy_fall) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // A conversion that saw enable low at any point is completed but its sample is thrown away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            discard_q    <= 1'b0;
            sample_valid <= 1'b0;
            sample_q     <= '0;
        end else begin
            busy_q       <= adc_busy;
            sample_valid <= capture & enable & ~discard_q;
            if (capture) sample_q <= sample_in;
            if (state == IDLE) begin
                discard_q <= 1'b0;
            end else if (!enable) begin
                discard_q <= 1'b1;
            end
        end
    end

    assign acc_sum     = acc + ACC_W'(sample_q);
    assign last_sample = (sample_cnt == CNT_W'(N_AVG - 1));
    assign push        = sample_valid & last_sample;
    assign word        = acc_sum[ACC_W-1 -: ADC_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (!enable || (sample_valid && last_sample)) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (sample_valid) begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;

    sync_fifo #(
        .WIDTH(ADC_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (word),
        .dout (m_data),
        .full (full),
        .empty(empty)
    );

    // Setting wins over clearing so an error in the clear cycle is never lost.
    assign overrun_set = (trigger && state != IDLE) || (push && full && !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad7980_acq.sv
// Self-checking bench for ad7980_acq: averaging table, enable abort, overrun and FIFO-full sequences.
// With AD7980_ACQ_OFFSET_EN defined, an extra instance exercises the offset subtraction.
module tb_ad7980_acq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        enable_a = 1'b0, busy_a = 1'b0, m_ready_a = 1'b0, clr_a = 1'b0;
    logic        start_a, m_valid_a, overrun_a;
    logic [15:0] data_a = '0, m_data_a;
    logic [15:0] mem_a [64];
    int          busy_len_a = 10, starts_a = 0, falls_a = 0, fall_cyc_a = 0;

    logic        enable_b = 1'b0, busy_b = 1'b0, m_ready_b = 1'b0, clr_b = 1'b0;
    logic        start_b, m_valid_b, overrun_b, prev_start_b = 1'b0;
    logic [15:0] data_b = '0, m_data_b;
    logic [15:0] mem_b [16];
    int          starts_b = 0, falls_b = 0, wide_b = 0;
    int          start_cyc_b [16];

    ad7980_acq #(.PERIOD(200), .AVG_LOG2(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a), .adc_start(start_a),
        .adc_busy(busy_a), .adc_data(data_a),
`ifdef AD7980_ACQ_OFFSET_EN
        .offset(16'd0),
`endif
        .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
        .overrun(overrun_a), .clr_overrun(clr_a)
    );

    ad7980_acq #(.PERIOD(200), .AVG_LOG2(0), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b), .adc_start(start_b),
        .adc_busy(busy_b), .adc_data(data_b),
`ifdef AD7980_ACQ_OFFSET_EN
        .offset(16'd0),
`endif
        .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .overrun(overrun_b), .clr_overrun(clr_b)
    );

`ifdef AD7980_ACQ_OFFSET_EN
    logic        enable_c = 1'b0, busy_c = 1'b0;
    logic        start_c, m_valid_c, overrun_c;
    logic [15:0] data_c = '0, m_data_c;
    logic [15:0] mem_c [4];
    int          falls_c = 0;

    ad7980_acq #(.PERIOD(50), .AVG_LOG2(1), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable_c), .adc_start(start_c),
        .adc_busy(busy_c), .adc_data(data_c), .offset(16'd1000),
        .m_data(m_data_c), .m_valid(m_valid_c), .m_ready(1'b0),
        .overrun(overrun_c), .clr_overrun(1'b0)
    );

    initial begin
        forever begin
            @(negedge clk);
            if (start_c) begin
                repeat (2) @(negedge clk);
                busy_c = 1'b1;
                repeat (5) @(negedge clk);
                busy_c  = 1'b0;
                data_c  = mem_c[falls_c];
                falls_c = falls_c + 1;
            end
        end
    end
`endif

    // ADC models: busy rises two cycles after a start, data appears as busy falls.
    initial begin
        int len;
        forever begin
            @(negedge clk);
            if (start_a) begin
                len      = busy_len_a;
                starts_a = starts_a + 1;
                repeat (2) @(negedge clk);
                busy_a = 1'b1;
                repeat (len) @(negedge clk);
                busy_a     = 1'b0;
                data_a     = mem_a[falls_a];
                fall_cyc_a = cyc;
                falls_a    = falls_a + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (start_b) begin
                if (starts_b < 16) start_cyc_b[starts_b] = cyc;
                starts_b = starts_b + 1;
                repeat (2) @(negedge clk);
                busy_b = 1'b1;
                repeat (10) @(negedge clk);
                busy_b  = 1'b0;
                data_b  = mem_b[falls_b];
                falls_b = falls_b + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (start_b && prev_start_b) wide_b <= wide_b + 1;
        prev_start_b <= start_b;
    end

    typedef struct {
        int s0;
        int s1;
        int s2;
        int s3;
        int expected;
    } vec_t;

    vec_t vecs [6];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int probe(input int sel);
        case (sel)
            0:       return falls_a;
            1:       return starts_a;
            2:       return falls_b;
            4:       return int'(m_valid_a);
            5:       return int'(m_valid_b);
`ifdef AD7980_ACQ_OFFSET_EN
            3:       return falls_c;
            6:       return int'(m_valid_c);
`endif
            default: return 0;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_for(input int sel, input int target, input int budget, input string name);
        int n = 0;
        while (probe(sel) < target && n < budget) begin
            step(1);
            n++;
        end
        if (probe(sel) < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: timeout, got %0d, expected %0d", name, probe(sel), target);
        end
    endtask

    task automatic apply_stimulus();
        vecs[0] = '{100, 200, 300, 400, 250};
        vecs[1] = '{0, 0, 0, 0, 0};
        vecs[2] = '{65535, 65535, 65535, 65535, 65535};
        vecs[3] = '{1, 2, 3, 5, 2};
        vecs[4] = '{7, 0, 0, 0, 1};
        vecs[5] = '{32768, 32768, 32767, 32767, 32767};
        for (int i = 0; i < 64; i++) mem_a[i] = '0;
        for (int i = 0; i < 6; i++) begin
            mem_a[4*i]   = 16'(vecs[i].s0);
            mem_a[4*i+1] = 16'(vecs[i].s1);
            mem_a[4*i+2] = 16'(vecs[i].s2);
            mem_a[4*i+3] = 16'(vecs[i].s3);
        end
        mem_a[24] = 16'd1000;
        mem_a[25] = 16'd1000;
        mem_a[26] = 16'd2000;
        mem_a[27] = 16'd4;
        mem_a[28] = 16'd8;
        mem_a[29] = 16'd12;
        mem_a[30] = 16'd16;
        for (int i = 0; i < 16; i++) mem_b[i] = 16'(11 * (i + 1));
`ifdef AD7980_ACQ_OFFSET_EN
        mem_c[0] = 16'd500;
        mem_c[1] = 16'd3000;
        mem_c[2] = 16'd0;
        mem_c[3] = 16'd0;
`endif
    endtask

    initial begin
        int s0;
        apply_stimulus();
        step(3);
        check_output("reset_start_a", int'(start_a), 0);
        check_output("reset_valid_a", int'(m_valid_a), 0);
        check_output("reset_data_a", int'(m_data_a), 0);
        check_output("reset_overrun_a", int'(overrun_a), 0);
        check_output("reset_start_b", int'(start_b), 0);
        check_output("reset_valid_b", int'(m_valid_b), 0);
        check_output("reset_data_b", int'(m_data_b), 0);
        check_output("reset_overrun_b", int'(overrun_b), 0);
        rst_n = 1'b1;
        step(2);
        enable_a = 1'b1;

        for (int i = 0; i < 6; i++) begin
            wait_for(0, 4 * (i + 1), 1200, "falls_a");
            wait_for(4, 1, 10, "valid_a");
            check_output("latency_a", cyc - fall_cyc_a, 2);
            check_output("avg_data_a", int'(m_data_a), vecs[i].expected);
            check_output("avg_overrun_a", int'(overrun_a), 0);
            m_ready_a = 1'b1;
            step(1);
            m_ready_a = 1'b0;
            check_output("pop_valid_a", int'(m_valid_a), 0);
        end

        // Enable drops mid-conversion after two of four samples.
        wait_for(0, 26, 600, "falls_a_pre_abort");
        wait_for(1, 27, 400, "starts_a_abort");
        step(3);
        enable_a = 1'b0;
        wait_for(0, 27, 100, "falls_a_abort");
        step(5);
        check_output("abort_no_output", int'(m_valid_a), 0);
        step(300);
        check_output("abort_no_start", starts_a, 27);
        enable_a = 1'b1;
        wait_for(0, 31, 2000, "falls_a_fresh");
        wait_for(4, 1, 10, "valid_a_fresh");
        check_output("fresh_avg_a", int'(m_data_a), 10);
        m_ready_a = 1'b1;
        step(1);
        m_ready_a = 1'b0;

        // Busy longer than the period makes the next trigger collide.
        busy_len_a = 250;
        s0 = starts_a;
        wait_for(1, s0 + 1, 400, "starts_a_long");
        busy_len_a = 10;
        step(215);
        check_output("overrun_set_a", int'(overrun_a), 1);
        check_output("skipped_start_a", starts_a, s0 + 1);
        wait_for(0, falls_a + 1, 100, "falls_a_long");
        step(2);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        check_output("overrun_clr_a", int'(overrun_a), 0);
        enable_a = 1'b0;

        // FIFO fills with m_ready held low; the fifth word is dropped.
        enable_b = 1'b1;
        wait_for(2, 4, 1200, "falls_b_four");
        step(3);
        check_output("full_no_overrun_b", int'(overrun_b), 0);
        check_output("head_held_b", int'(m_data_b), 11);
        wait_for(2, 5, 400, "falls_b_five");
        step(3);
        enable_b = 1'b0;
        check_output("drop_overrun_b", int'(overrun_b), 1);
        for (int k = 1; k < 5; k++) begin
            check_output("start_interval_b", start_cyc_b[k] - start_cyc_b[k-1], 200);
        end
        check_output("start_width_b", wide_b, 0);
        for (int k = 0; k < 4; k++) begin
            check_output("fifo_valid_b", int'(m_valid_b), 1);
            check_output("fifo_order_b", int'(m_data_b), 11 * (k + 1));
            m_ready_b = 1'b1;
            step(1);
            m_ready_b = 1'b0;
        end
        check_output("fifo_empty_b", int'(m_valid_b), 0);

`ifdef AD7980_ACQ_OFFSET_EN
        enable_c = 1'b1;
        wait_for(3, 2, 300, "falls_c");
        wait_for(6, 1, 10, "valid_c");
        check_output("offset_avg_c", int'(m_data_c), 1000);
        enable_c = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad7980_acq.md
AD7980_ACQ -- requirements
Module: ad7980_acq

Interface
REQ-001 SHALL have parameter PERIOD, default 200, trigger period in clk cycles (>= 2).
REQ-002 SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per output word (0..4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output FIFO depth in words (power of 2, >= 2).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-005 clk  input  1  system clock, shared with the ADC interface stage.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  acquisition enable.
REQ-008 adc_start  output  1  one-cycle conversion request to the ADC interface stage.
REQ-009 adc_busy  input  1  ADC interface stage busy; high during serial readout.
REQ-010 adc_data  input  16  unsigned conversion result; valid from the cycle adc_busy falls.
REQ-011 m_data  output  16  averaged sample.
REQ-012 m_valid  output  1  m_data valid; m_ready  input  1  consumer accepts.
REQ-013 overrun  output  1  sticky error flag; clr_overrun  input  1  clears it.

Function
REQ-014 Period counter SHALL count 0..PERIOD-1 while enable=1, wrap to 0, and hold at 0 while enable=0.
REQ-015 Trigger SHALL occur on the cycle the period counter equals PERIOD-1.
REQ-016 FSM states: IDLE, WAIT_BUSY, CONV.
REQ-017 IDLE + trigger: adc_start=1 for exactly one cycle, go to WAIT_BUSY.
REQ-018 WAIT_BUSY: go to CONV on the first cycle adc_busy=1.
REQ-019 CONV: on registered busy falling edge (previous 1, current 0), sample adc_data that cycle, go to IDLE.
REQ-020 Trigger outside IDLE SHALL emit no adc_start and SHALL set overrun.
REQ-021 Each captured sample SHALL add into an unsigned accumulator of 16+AVG_LOG2 bits, which cannot overflow.
REQ-022 On the 2^AVG_LOG2-th sample, the output word (accumulated sum including that sample, shifted right AVG_LOG2, truncated) SHALL be pushed to the FIFO and the accumulator cleared in the same cycle.
REQ-023 Latency from the capture cycle of the final sample to m_valid=1 (FIFO previously empty) SHALL be 2 cycles.
REQ-024 The FIFO SHALL pop on m_valid & m_ready; m_data SHALL be FIFO head, stable while m_valid & ~m_ready.
REQ-025 A push while full and not popping SHALL be dropped and SHALL set overrun; push and pop in the same cycle while full SHALL both succeed.
REQ-026 m_valid SHALL be 0 when the FIFO is empty; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 enable falling SHALL stop new triggers; an in-flight conversion SHALL complete, its sample SHALL be discarded, and the accumulator SHALL be cleared; the FIFO SHALL be retained.
REQ-028 clr_overrun SHALL clear overrun; a simultaneous set event SHALL take priority.

Reset
REQ-029 On rst_n=0: FSM=IDLE; counter, accumulator, sample count, and FIFO pointers=0; adc_start=0, m_valid=0, m_data=0, overrun=0.
REQ-030 Reset asserted mid-conversion SHALL abandon it; after release, adc_busy SHALL be ignored until the next adc_start.

Configuration
REQ-031 Macro AD7980_ACQ_OFFSET_EN defined: add input port offset (16, unsigned); each sample SHALL become max(adc_data - offset, 0) before accumulation.
REQ-032 Macro undefined: no offset port; samples SHALL be accumulated unmodified.

Structure
REQ-033 Package ad7980_pkg SHALL hold the FSM state enum and the ADC data width constant (16).
REQ-034 FIFO SHALL be a sub-module sync_fifo (parameters width and depth; ports full/empty/push/pop).

Verification
REQ-035 AVG_LOG2=2, ADC model returns 100,200,300,400 -> one word m_data=250, overrun=0.
REQ-036 AVG_LOG2=0, PERIOD=200 -> adc_start pulses exactly every 200 cycles, each 1 cycle wide.
REQ-037 ADC model holds adc_busy for 250 cycles with PERIOD=200 -> a trigger is skipped, overrun=1; clr_overrun -> overrun=0.
REQ-038 m_ready=0, AVG_LOG2=0, 5 samples, FIFO_DEPTH=4 -> 4 words held in order, 5th dropped, overrun=1.
REQ-039 enable dropped after 2 of 4 samples, then re-enabled -> the next output averages 4 fresh samples only.
REQ-040 AD7980_ACQ_OFFSET_EN, offset=1000, samples 500 and 3000, AVG_LOG2=1 -> m_data=1000.
